// File: rtl/mac_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mac_controller
// Description : Sequencing FSM for the 4-term complex multiply-accumulate
//               datapath. Issues argument load / accumulator clear, then for
//               each term: select, multiplier start, wait for ready,
//               accumulate. Reports done or a multiplier timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_controller #(
    parameter int NUM_TERMS = 4,   // products per run, 1..4
    parameter int TIMEOUT   = 64   // max MWAIT cycles per term, 0 = no watchdog
) (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active-low
    input  logic       start,
    input  logic       CMReady,
    output logic       ldArgs,
    output logic       init0Acc,
    output logic [1:0] seli,
    output logic       CMStart,
    output logic       ldAcc,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // Wait counter must be able to hold TIMEOUT itself; keep at least 1 bit.
    localparam int                  c_WCNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_WCNT_W-1:0] c_TIMEOUT_CNT = c_WCNT_W'(TIMEOUT);
    localparam logic [1:0]          c_LAST_IDX    = 2'(NUM_TERMS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_MSTART = 3'd2,
        S_MHOLD  = 3'd3,
        S_MWAIT  = 3'd4,
        S_ACC    = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [c_WCNT_W-1:0] wcnt_q, wcnt_d;
    logic                err_q, err_d;
    logic [c_WCNT_W-1:0] wcnt_inc;

    assign wcnt_inc = wcnt_q + 1'b1;

    // State, term index, wait counter and sticky error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic plus Moore decode of the datapath strobes.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wcnt_d   = wcnt_q;
        err_d    = err_q;
        ldArgs   = 1'b0;
        init0Acc = 1'b0;
        seli     = 2'd0;
        CMStart  = 1'b0;
        ldAcc    = 1'b0;
        done     = 1'b0;
        busy     = (state_q != S_IDLE);
        err      = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                ldArgs   = 1'b1;
                init0Acc = 1'b1;
                idx_d    = 2'd0;
                state_d  = S_MSTART;
            end
            S_MSTART: begin
                CMStart = 1'b1;
                seli    = idx_q;
                wcnt_d  = '0;
                state_d = S_MHOLD;
            end
            S_MHOLD: begin
                // Ready may still be asserted from the previous term: ignore it.
                seli    = idx_q;
                state_d = S_MWAIT;
            end
            S_MWAIT: begin
                seli = idx_q;
                if (CMReady) begin
                    state_d = S_ACC;
                end else begin
                    wcnt_d = wcnt_inc;
                    if ((TIMEOUT != 0) && (wcnt_inc == c_TIMEOUT_CNT)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_ACC: begin
                ldAcc = 1'b1;
                seli  = idx_q;
                if (idx_q == c_LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_MSTART;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mac_controller
// Description : Scoreboard bench for mac_controller. Stimulus pushes expected
//               strobe events (cycle + strobe vector); monitors pop and compare
//               whenever a strobe appears. A small multiplier model drives
//               CMReady with a configurable extra delay per term.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst    = 1'b0;
    logic start4 = 1'b0;
    logic start1 = 1'b0;
    logic rdy4   = 1'b0;
    logic rdy1   = 1'b0;

    logic       ldArgs4, init0Acc4, CMStart4, ldAcc4, busy4, done4, err4;
    logic [1:0] seli4;
    logic       ldArgs1, init0Acc1, CMStart1, ldAcc1, busy1, done1, err1;
    logic [1:0] seli1;

    mac_controller #(.NUM_TERMS(4), .TIMEOUT(8)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .CMReady(rdy4),
        .ldArgs(ldArgs4), .init0Acc(init0Acc4), .seli(seli4), .CMStart(CMStart4),
        .ldAcc(ldAcc4), .busy(busy4), .done(done4), .err(err4)
    );

    mac_controller #(.NUM_TERMS(1), .TIMEOUT(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .CMReady(rdy1),
        .ldArgs(ldArgs1), .init0Acc(init0Acc1), .seli(seli1), .CMStart(CMStart1),
        .ldAcc(ldAcc1), .busy(busy1), .done(done1), .err(err1)
    );

    // Event vector layout: {ldArgs, init0Acc, CMStart, ldAcc, done, seli[1:0], busy}
    typedef struct {
        int         cyc;
        logic [7:0] ev;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int extra4 = 0;
    int k4     = 100;
    int k1     = 100;

    int last_done4 = 0;
    int ldargs4_n  = 0;
    int ldacc4_n   = 0;
    int done1_n    = 0;
    logic       win4  = 1'b0;
    logic [1:0] wsel4 = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input bit to1, input int c, input logic [7:0] ev);
        exp_t e;
        e.cyc = c;
        e.ev  = ev;
        if (to1) q1.push_back(e);
        else     q4.push_back(e);
    endtask

    // Expected strobes of one run launched with start sampled at the edge after t0.
    task automatic push_run(input bit to1, input int t0, input int nt, input int ex, input int maxrel);
        int         base;
        logic [1:0] s;
        if (1 <= maxrel) push_ev(to1, t0 + 1, 8'b1100_0001);
        for (int k = 0; k < nt; k++) begin
            base = 2 + k * (4 + ex);
            s    = k[1:0];
            if (base <= maxrel)          push_ev(to1, t0 + base,          {5'b00100, s, 1'b1});
            if (base + 3 + ex <= maxrel) push_ev(to1, t0 + base + 3 + ex, {5'b00010, s, 1'b1});
        end
        if (2 + nt * (4 + ex) <= maxrel) push_ev(to1, t0 + 2 + nt * (4 + ex), 8'b0000_1001);
    endtask

    task automatic wait_rel(input int t0, input int r);
        while (cyc - t0 < r) @(negedge clk);
    endtask

    // Multiplier model: ready holds its stale value through the blanking
    // cycle, then is low for 'extra' cycles before rising.
    always @(negedge clk) begin
        if (CMStart4) k4 = 0;
        else begin
            k4 = k4 + 1;
            if (k4 >= 2) rdy4 = ((k4 - 2) >= extra4);
        end
    end

    always @(negedge clk) begin
        if (CMStart1) k1 = 0;
        else begin
            k1 = k1 + 1;
            if (k1 >= 2) rdy1 = 1'b1;
        end
    end

    // Monitor for the 4-term instance: scoreboard pop plus seli stability.
    always @(negedge clk) begin : mon4
        logic [7:0] ev;
        exp_t       e;
        if (!rst) begin
            win4 = 1'b0;
        end else begin
            ev = {ldArgs4, init0Acc4, CMStart4, ldAcc4, done4, seli4, busy4};
            if (ldArgs4) ldargs4_n++;
            if (ldAcc4)  ldacc4_n++;
            if (done4)   last_done4 = cyc;
            if (ldArgs4 | CMStart4 | ldAcc4 | done4) begin
                if (q4.size() == 0) chk("dut4_unexpected_strobe", {24'd0, ev}, 32'd0);
                else begin
                    e = q4.pop_front();
                    chk("dut4_strobe_cycle", e.cyc == cyc ? 32'd1 : 32'd0, 32'd1);
                    chk("dut4_strobe_vec", {24'd0, ev}, {24'd0, e.ev});
                end
            end
            if (CMStart4) begin
                win4  = 1'b1;
                wsel4 = seli4;
            end else if (win4 && busy4) begin
                chk("dut4_seli_stable", {30'd0, seli4}, {30'd0, wsel4});
                if (ldAcc4) win4 = 1'b0;
            end else begin
                win4 = 1'b0;
            end
        end
    end

    // Monitor for the single-term instance.
    always @(negedge clk) begin : mon1
        logic [7:0] ev;
        exp_t       e;
        if (rst) begin
            ev = {ldArgs1, init0Acc1, CMStart1, ldAcc1, done1, seli1, busy1};
            if (done1) done1_n++;
            if (ldArgs1 | CMStart1 | ldAcc1 | done1) begin
                if (q1.size() == 0) chk("dut1_unexpected_strobe", {24'd0, ev}, 32'd0);
                else begin
                    e = q1.pop_front();
                    chk("dut1_strobe_cycle", e.cyc == cyc ? 32'd1 : 32'd0, 32'd1);
                    chk("dut1_strobe_vec", {24'd0, ev}, {24'd0, e.ev});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int t0;
        int n0;
        int m0;

        // Reset state of both instances
        repeat (2) @(negedge clk);
        chk("reset_outputs4", {23'd0, ldArgs4, init0Acc4, seli4, CMStart4, ldAcc4, busy4, done4, err4}, 32'd0);
        chk("reset_outputs1", {23'd0, ldArgs1, init0Acc1, seli1, CMStart1, ldAcc1, busy1, done1, err1}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // A: single start pulse, ready one cycle after CMStart falls
        extra4 = 0;
        n0 = ldacc4_n;
        t0 = cyc;
        push_run(1'b0, t0, 4, 0, 1000);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_rel(t0, 19);
        chk("A_done_cycle", last_done4 - t0, 32'd18);
        chk("A_ldacc_count", ldacc4_n - n0, 32'd4);
        chk("A_busy_after", {31'd0, busy4}, 32'd0);
        chk("A_queue_empty", q4.size(), 32'd0);

        // B: three extra ready-delay cycles per term
        extra4 = 3;
        n0 = ldacc4_n;
        t0 = cyc;
        push_run(1'b0, t0, 4, 3, 1000);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_rel(t0, 32);
        chk("B_done_cycle", last_done4 - t0, 32'd30);
        chk("B_ldacc_count", ldacc4_n - n0, 32'd4);
        chk("B_queue_empty", q4.size(), 32'd0);

        // C: start re-asserted during cycles 3..10 is ignored
        extra4 = 0;
        m0 = ldargs4_n;
        t0 = cyc;
        push_run(1'b0, t0, 4, 0, 1000);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_rel(t0, 3);
        start4 = 1'b1;
        wait_rel(t0, 11);
        start4 = 1'b0;
        wait_rel(t0, 23);
        chk("C_ldargs_count", ldargs4_n - m0, 32'd1);
        chk("C_done_cycle", last_done4 - t0, 32'd18);
        chk("C_queue_empty", q4.size(), 32'd0);

        // D: asynchronous reset during MWAIT of term 2
        t0 = cyc;
        push_run(1'b0, t0, 4, 0, 10);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_rel(t0, 12);
        chk("D_busy_before_reset", {31'd0, busy4}, 32'd1);
        #2 rst = 1'b0;
        #1 chk("D_async_reset_outputs", {23'd0, ldArgs4, init0Acc4, seli4, CMStart4, ldAcc4, busy4, done4, err4}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("D_idle_after_release", {23'd0, ldArgs4, init0Acc4, seli4, CMStart4, ldAcc4, busy4, done4, err4}, 32'd0);
        chk("D_queue_empty", q4.size(), 32'd0);

        // E: multiplier ready stuck low -> watchdog after 8 MWAIT cycles
        extra4 = 100000;
        n0 = ldacc4_n;
        t0 = cyc;
        push_run(1'b0, t0, 4, 0, 2);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_rel(t0, 11);
        chk("E_err_before", {31'd0, err4}, 32'd0);
        chk("E_busy_before", {31'd0, busy4}, 32'd1);
        wait_rel(t0, 12);
        chk("E_err_set", {31'd0, err4}, 32'd1);
        chk("E_busy_dropped", {31'd0, busy4}, 32'd0);
        wait_rel(t0, 20);
        chk("E_err_sticky", {31'd0, err4}, 32'd1);
        chk("E_no_ldacc", ldacc4_n - n0, 32'd0);
        chk("E_queue_empty", q4.size(), 32'd0);

        // F: next accepted start clears err; run completes normally
        extra4 = 0;
        chk("F_err_held_in_idle", {31'd0, err4}, 32'd1);
        t0 = cyc;
        push_run(1'b0, t0, 4, 0, 1000);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("F_err_cleared", {31'd0, err4}, 32'd0);
        wait_rel(t0, 20);
        chk("F_done_cycle", last_done4 - t0, 32'd18);
        chk("F_queue_empty", q4.size(), 32'd0);

        // G: single-term instance with start held high -> 7-cycle repeating runs
        n0 = done1_n;
        t0 = cyc;
        push_run(1'b1, t0, 1, 0, 1000);
        push_run(1'b1, t0 + 7, 1, 0, 1000);
        push_run(1'b1, t0 + 14, 1, 0, 1000);
        start1 = 1'b1;
        wait_rel(t0, 16);
        start1 = 1'b0;
        wait_rel(t0, 28);
        chk("G_done_count", done1_n - n0, 32'd3);
        chk("G_busy_after", {31'd0, busy1}, 32'd0);
        chk("G_queue_empty", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
